// File: rtl/trng_vn_packer_pkg.sv
// trng_vn_packer: shared widths, defaults and the
// corrector pair-state encoding.
package trng_pkg;

  localparam int BYTE_W         = 8;
  localparam int RCT_LIMIT_DEF  = 32;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int RCT_CNT_W      = 8;

  typedef enum logic {
    PAIR_EMPTY,
    PAIR_HAVE_FIRST
  } pair_st_e;

  typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/trng_vn_packer_if.sv
// trng_vn_packer_if: byte stream from the packer
// FIFO head to the UART transmitter.
interface trng_vn_packer_if;

  logic [trng_pkg::BYTE_W-1:0] o_data;
  logic                        o_valid;
  logic                        i_ready;

  modport master (
    output o_data,
    output o_valid,
    input  i_ready
  );

  modport slave (
    input  o_data,
    input  o_valid,
    output i_ready
  );

endinterface

// File: rtl/trng_vn_packer_fifo.sv
// trng_byte_fifo: small byte FIFO, push wins when
// full only if a pop frees a slot the same edge.
module trng_byte_fifo
  import trng_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic  clk_sys,
  input  logic  rst,
  input  logic  push_i,
  input  byte_t din_i,
  input  logic  pop_i,
  output byte_t dout_o,
  output logic  full_o,
  output logic  empty_o,
  output logic  ovf_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  byte_t       mem_q [DEPTH];
  logic        ovf_q, ovf_d;

  logic        do_push;
  logic        do_pop;
  logic        full;
  logic        empty;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    ovf_d = push_i && full && !do_pop;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
      if (do_push)
        mem_q[wr_q[AW-1:0]] <= din_i;
    end
  end

  // Empty head reads as zero so o_data matches reset.
  assign dout_o  = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign full_o  = full;
  assign empty_o = empty;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/trng_vn_packer.sv
// trng_vn_packer: von Neumann corrector, repetition
// count health test and MSB-first byte packer.
module trng_vn_packer
  import trng_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int RCT_LIMIT  = RCT_LIMIT_DEF
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_bit,
  input  logic              i_bit_valid,
  trng_vn_packer_if.master  out_if,
  output logic              o_overflow,
  output logic              o_health_fail
);

  localparam logic [RCT_CNT_W-1:0] LIM =
    RCT_CNT_W'(RCT_LIMIT);

  pair_st_e state_q, state_d;
  logic     first_q, first_d;

  byte_t    shift_q, shift_d;
  logic [2:0] fill_q, fill_d;

  logic [RCT_CNT_W-1:0] cnt_q, cnt_d;
  logic     prev_q, prev_d;
  logic     hf_q, hf_d;

  logic     accept;
  logic     store_first;
  logic     emit;
  logic     byte_done;
  byte_t    byte_val;

  logic     f_full;
  logic     f_empty;
  logic     f_pop;
  byte_t    f_dout;
  logic     f_ovf;

  assign accept = i_bit_valid && i_en && !hf_q;

  // Pair state machine
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) state_q <= PAIR_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PAIR_EMPTY: begin
        if (i_en && accept)
          state_d = PAIR_HAVE_FIRST;
      end
      PAIR_HAVE_FIRST: begin
        if (!i_en || accept)
          state_d = PAIR_EMPTY;
      end
      default: state_d = PAIR_EMPTY;
    endcase
  end

  always_comb begin
    store_first = 1'b0;
    emit        = 1'b0;
    unique case (state_q)
      PAIR_EMPTY:
        store_first = accept;
      PAIR_HAVE_FIRST:
        emit = accept && (first_q != i_bit);
      default: begin
        store_first = 1'b0;
        emit        = 1'b0;
      end
    endcase
  end

  assign first_d = store_first ? i_bit : first_q;

  // Packer: the emitted bit equals the first of the pair.
  assign byte_val  = {shift_q[BYTE_W-2:0], first_q};
  assign byte_done = emit && (fill_q == 3'd7);

  always_comb begin
    shift_d = shift_q;
    fill_d  = fill_q;
    if (!i_en) begin
      shift_d = '0;
      fill_d  = '0;
    end else if (emit) begin
      shift_d = byte_val;
      fill_d  = fill_q + 3'd1;
    end
  end

  // Repetition-count test on every accepted raw bit
  always_comb begin
    cnt_d  = cnt_q;
    prev_d = prev_q;
    hf_d   = hf_q;
    if (!i_en) begin
      cnt_d = '0;
    end else if (accept) begin
      prev_d = i_bit;
      if (cnt_q == '0 || i_bit != prev_q)
        cnt_d = RCT_CNT_W'(1);
      else if (cnt_q < LIM)
        cnt_d = cnt_q + RCT_CNT_W'(1);
      if (cnt_d == LIM)
        hf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      first_q <= 1'b0;
      shift_q <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      hf_q    <= 1'b0;
    end else begin
      first_q <= first_d;
      shift_q <= shift_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      hf_q    <= hf_d;
    end
  end

  assign f_pop = !f_empty && out_if.i_ready;

  trng_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .rst     (rst),
    .push_i  (byte_done),
    .din_i   (byte_val),
    .pop_i   (f_pop),
    .dout_o  (f_dout),
    .full_o  (f_full),
    .empty_o (f_empty),
    .ovf_o   (f_ovf)
  );

  assign out_if.o_data  = f_dout;
  assign out_if.o_valid = !f_empty;
  assign o_overflow     = f_ovf;
  assign o_health_fail  = hf_q;

  logic unused;
  assign unused = f_full;

endmodule

// File: tb/tb_trng_vn_packer.sv
// tb_trng_vn_packer: directed checks of corrector,
// packer, FIFO backpressure, RCT and enable/reset.
module tb_trng_vn_packer;

  logic clk_sys = 1'b0;
  logic rst;
  logic i_en;
  logic i_bit;
  logic i_bit_valid;
  logic o_overflow;
  logic o_health_fail;

  int errors = 0;
  int checks = 0;
  int ovf_cnt = 0;
  logic [7:0] got [$];

  trng_vn_packer_if bus ();

  trng_vn_packer #(
    .FIFO_DEPTH (4),
    .RCT_LIMIT  (32)
  ) dut (
    .clk_sys       (clk_sys),
    .rst           (rst),
    .i_en          (i_en),
    .i_bit         (i_bit),
    .i_bit_valid   (i_bit_valid),
    .out_if        (bus.master),
    .o_overflow    (o_overflow),
    .o_health_fail (o_health_fail)
  );

  always #5 clk_sys = ~clk_sys;

  // Bytes that leave the FIFO and overflow pulses
  always @(negedge clk_sys) begin
    if (!rst && bus.o_valid && bus.i_ready)
      got.push_back(bus.o_data);
    if (!rst && o_overflow)
      ovf_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic bit1(input logic b);
    i_bit       = b;
    i_bit_valid = 1'b1;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle(input int n);
    i_bit_valid = 1'b0;
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // Each data bit v as a raw pair (v, ~v)
  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      bit1(v[i]);
      bit1(~v[i]);
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #3;
    chk("rst_data",  bus.o_data,    32'h00);
    chk("rst_valid", bus.o_valid,   32'h0);
    chk("rst_ovf",   o_overflow,    32'h0);
    chk("rst_hf",    o_health_fail, 32'h0);
    @(posedge clk_sys);
    #1;
    rst = 1'b0;
    idle(1);
  endtask

  initial begin
    rst         = 1'b1;
    i_en        = 1'b1;
    i_bit       = 1'b0;
    i_bit_valid = 1'b0;
    bus.i_ready = 1'b1;
    #2;
    pulse_rst();

    // Corrector mapping
    got.delete();
    send_byte(8'hFF);
    chk("lat_valid", bus.o_valid, 32'h1);
    chk("lat_data",  bus.o_data,  32'hFF);
    send_byte(8'h00);
    send_byte(8'hAA);
    idle(3);
    chk("map_n", got.size(), 32'd3);
    if (got.size() == 3) begin
      chk("map_0", got[0], 32'hFF);
      chk("map_1", got[1], 32'h00);
      chk("map_2", got[2], 32'hAA);
    end
    chk("map_idle", bus.o_valid, 32'h0);

    // Discarded pairs interleaved
    got.delete();
    for (int i = 0; i < 4; i++) begin
      bit1(1'b1); bit1(1'b0);
      bit1(1'b0); bit1(1'b0);
      bit1(1'b0); bit1(1'b1);
      bit1(1'b1); bit1(1'b1);
    end
    idle(3);
    chk("disc_n", got.size(), 32'd1);
    if (got.size() == 1)
      chk("disc_0", got[0], 32'hAA);

    // Backpressure and overflow
    got.delete();
    ovf_cnt = 0;
    bus.i_ready = 1'b0;
    for (int b = 1; b <= 4; b++)
      send_byte(8'(b));
    chk("bp_noovf", ovf_cnt, 32'd0);
    send_byte(8'h05);
    chk("bp_ovf_hi", o_overflow, 32'h1);
    idle(1);
    chk("bp_ovf_lo", o_overflow, 32'h0);
    chk("bp_head",   bus.o_data, 32'h01);
    chk("bp_hold_v", bus.o_valid, 32'h1);
    idle(2);
    chk("bp_hold_d", bus.o_data, 32'h01);
    chk("bp_ovf_n",  ovf_cnt, 32'd1);
    bus.i_ready = 1'b1;
    idle(6);
    chk("bp_n", got.size(), 32'd4);
    if (got.size() == 4)
      for (int i = 0; i < 4; i++)
        chk("bp_order", got[i], 32'(i + 1));
    chk("bp_empty", bus.o_valid, 32'h0);

    // Enable drop after first bit of a pair
    got.delete();
    bit1(1'b1);
    i_bit_valid = 1'b0;
    i_en = 1'b0;
    idle(1);
    i_en = 1'b1;
    send_byte(8'h3C);
    idle(3);
    chk("en_n", got.size(), 32'd1);
    if (got.size() == 1)
      chk("en_0", got[0], 32'h3C);

    // Reset mid-byte
    for (int i = 0; i < 5; i++) begin
      bit1(1'b1); bit1(1'b0);
    end
    idle(1);
    pulse_rst();
    got.delete();
    send_byte(8'hFF);
    idle(3);
    chk("rst_n", got.size(), 32'd1);
    if (got.size() == 1)
      chk("rst_0", got[0], 32'hFF);

    // Health test
    for (int i = 0; i < 31; i++)
      bit1(1'b1);
    chk("hf_31", o_health_fail, 32'h0);
    bit1(1'b1);
    chk("hf_32", o_health_fail, 32'h1);
    got.delete();
    send_byte(8'hFF);
    idle(3);
    chk("hf_nobyte", got.size(), 32'd0);
    chk("hf_novalid", bus.o_valid, 32'h0);
    i_en = 1'b0;
    idle(2);
    i_en = 1'b1;
    idle(1);
    chk("hf_sticky", o_health_fail, 32'h1);
    pulse_rst();
    chk("hf_clear", o_health_fail, 32'h0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
